// File: rtl/jump_index_encoder.sv
// -----------------------------------------------------------------------------
// jump_index_encoder
//
// Purpose:
//   Turns a byte-addressed jump target into the SIZE-bit J-format instruction
//   index. This undoes the datapath's shift-left-2 jump-address path. The block
//   flags targets that the J format cannot express, which are misaligned targets
//   and targets outside the 256 MB region of PC+4. Requests arrive through a
//   valid/ready handshake. Encoded results are queued in a 2-entry FIFO and
//   leave through a second valid/ready handshake.
//
// Configuration:
//   JUMP_REGION_CHECK_EN - when defined, the block compares in_target[31:SIZE+2]
//                          against in_pc4[31:SIZE+2], raises out_region_err, and
//                          counts region errors in err_count. When undefined,
//                          out_region_err is tied 0, in_pc4 is ignored, and
//                          err_count counts only misaligned requests.
//
// Ports:
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   in_valid        in   request present
//   in_ready        out  request accepted this cycle when in_valid is also high
//   in_target[31:0] in   byte-addressed jump target
//   in_pc4[31:0]    in   PC+4 of the jump instruction
//   out_valid       out  FIFO head holds an entry
//   out_ready       in   consumer takes the head this cycle
//   out_index       out  head entry index, equal to target[SIZE+1:2]
//   out_misaligned  out  head entry: target[1:0] != 0
//   out_region_err  out  head entry: target region differs from PC+4 region
//   err_count[7:0]  out  saturating count of accepted requests with a flag set
// -----------------------------------------------------------------------------
module jump_index_encoder #(
  parameter int SIZE = 26
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_target,
  input  logic [31:0]     in_pc4,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_index,
  output logic            out_misaligned,
  output logic            out_region_err,
  output logic [7:0]      err_count
);

  localparam logic [1:0] FULL_COUNT = 2'd2;
  localparam logic [7:0] ERR_MAX    = 8'hFF;

  // Combinational encode of the incoming request.
  logic [SIZE-1:0] w_index;
  logic            w_misaligned;
  logic            w_region_err;
  logic            w_push;
  logic            w_pop;

  // Misaligned targets still produce an index. The low two bits are dropped,
  // and the error is reported through the flag.
  assign w_index      = in_target[SIZE+1:2];
  assign w_misaligned = |in_target[1:0];

`ifdef JUMP_REGION_CHECK_EN
  // A J-type jump keeps the upper bits of PC+4. A target whose upper bits
  // differ from those of PC+4 cannot be reached by this instruction.
  assign w_region_err = (in_target[31:SIZE+2] != in_pc4[31:SIZE+2]);
`else
  // With the region check disabled, these inputs feed no logic. The signal
  // below only collects them so they are visibly accounted for.
  logic w_unused_region;
  assign w_unused_region = ^{in_pc4, in_target[31:SIZE+2]};
  assign w_region_err    = 1'b0;
`endif

  // FIFO state: two storage cells, 1-bit pointers that wrap modulo 2, and an
  // occupancy count from 0 to 2.
  logic [SIZE-1:0] r_mem_index [2];
  logic            r_mem_mis   [2];
  logic            r_mem_rgn   [2];
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_count;
  logic [7:0]      r_err_count;

  // A full FIFO refuses input even if the head is popped in the same cycle.
  // This keeps in_ready independent of out_ready.
  assign in_ready  = (r_count != FULL_COUNT);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // The head fields come straight from registered storage. Because the storage
  // cells are cleared on reset, the head fields read 0 while the FIFO is empty
  // after reset.
  assign out_index      = r_mem_index[r_rd_ptr];
  assign out_misaligned = r_mem_mis[r_rd_ptr];
  assign out_region_err = r_mem_rgn[r_rd_ptr];
  assign err_count      = r_err_count;

  // NOTE: every assignment in a clocked block is non-blocking. Each register
  //       then takes its next value from the values that existed before the
  //       edge, however the statements are ordered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage array is reset as well as the control state, so the
      //       head fields are defined after reset rather than X.
      for (int i = 0; i < 2; i++) begin
        r_mem_index[i] <= '0;
        r_mem_mis[i]   <= 1'b0;
        r_mem_rgn[i]   <= 1'b0;
      end
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_err_count <= 8'd0;
    end else begin
      if (w_push) begin
        r_mem_index[r_wr_ptr] <= w_index;
        r_mem_mis[r_wr_ptr]   <= w_misaligned;
        r_mem_rgn[r_wr_ptr]   <= w_region_err;
        r_wr_ptr              <= ~r_wr_ptr;
      end

      // A push and a pop at count 1 advance both pointers. The read pointer
      // then lands on the cell that was just written, so the new entry
      // becomes the head.
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end

      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      if (w_push && (w_misaligned || w_region_err) && (r_err_count != ERR_MAX)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_jump_index_encoder.sv
// -----------------------------------------------------------------------------
// tb_jump_index_encoder
//
// Self-checking bench for jump_index_encoder. A reference model in the bench
// holds the FIFO contents as a queue of encoded entries. It derives each entry
// with plain arithmetic on the target and PC+4, and it keeps a saturating error
// total. Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_jump_index_encoder;

  localparam int SIZE = 26;

  typedef struct {
    logic [SIZE-1:0] idx;
    bit              mis;
    bit              rgn;
  } entry_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_target;
  logic [31:0]     in_pc4;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] out_index;
  logic            out_misaligned;
  logic            out_region_err;
  logic [7:0]      err_count;

  int n_tests = 0;
  int n_fail  = 0;

  entry_t mq[$];
  int     m_err = 0;

  jump_index_encoder #(.SIZE(SIZE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_target      (in_target),
    .in_pc4         (in_pc4),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_index      (out_index),
    .out_misaligned (out_misaligned),
    .out_region_err (out_region_err),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  // The index is the target's word number, truncated to SIZE bits.
  function automatic entry_t model_encode(input logic [31:0] target, input logic [31:0] pc4);
    entry_t e;
    longint unsigned t;
    longint unsigned p;
    t = target;
    p = pc4;
    e.idx = SIZE'((t / 4) % (64'd1 << SIZE));
    e.mis = (t % 4) != 0;
`ifdef JUMP_REGION_CHECK_EN
    e.rgn = (t >> (SIZE + 2)) != (p >> (SIZE + 2));
`else
    e.rgn = 1'b0;
    if (p == 64'd0) e.rgn = 1'b0;
`endif
    return e;
  endfunction

  // Advances one clock and updates the model from the inputs held across that
  // clock edge. The task makes no comparisons.
  task automatic step();
    bit     do_push;
    bit     do_pop;
    entry_t e;
    do_pop  = (mq.size() > 0) && out_ready;
    do_push = in_valid && (mq.size() < 2);
    e       = model_encode(in_target, in_pc4);
    @(posedge clk);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      mq.push_back(e);
      if (e.mis || e.rgn) m_err = (m_err >= 255) ? 255 : m_err + 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_target = '0;
    in_pc4    = '0;
    mq.delete();
    m_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++;
    if ({out_index, out_misaligned, out_region_err} !== '0) begin
      n_fail++; $display("FAIL reset_head got idx=%h mis=%b rgn=%b want 0", out_index, out_misaligned, out_region_err);
    end
    n_tests++;
    if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count got %0d want 0", err_count); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    in_valid  = 1'b1;
    in_target = 32'h0000_0004;
    in_pc4    = 32'h0000_0100;
    step();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_index !== 26'h0000001 || out_misaligned !== 1'b0 ||
        out_region_err !== 1'b0 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL single got v=%b idx=%h mis=%b rgn=%b err=%0d want v=1 idx=1 mis=0 rgn=0 err=0",
               out_valid, out_index, out_misaligned, out_region_err, err_count);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got v=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [SIZE-1:0] got[$];
    bit              accept;
    logic [31:0]     tgts[3] = '{32'h8, 32'hC, 32'h10};
    out_ready = 1'b0;
    in_pc4    = 32'h0000_0100;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_target = tgts[i];
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_%0d got %b want 1", i, in_ready); end
      step();
    end
    in_target = tgts[2];
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    step();
    n_tests++;
    if (in_ready !== 1'b0 || out_index !== 26'd2) begin
      n_fail++; $display("FAIL bp_hold got ready=%b idx=%0d want ready=0 idx=2", in_ready, out_index);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12 && got.size() < 3; c++) begin
      if (out_valid) got.push_back(out_index);
      accept = in_valid && in_ready;
      step();
      if (accept) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_tests++;
    if (got.size() != 3) begin
      n_fail++; $display("FAIL bp_count got %0d outputs want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (got[i] !== SIZE'(i + 2)) begin
          n_fail++; $display("FAIL bp_order_%0d got %0d want %0d", i, got[i], i + 2);
        end
      end
    end
  endtask

  task automatic test_error_flags();
    int exp_err;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_target = 32'h0000_0006;
    in_pc4    = 32'h0000_0004;
    step();
    in_valid = 1'b0;
    n_tests++;
    if (out_index !== 26'd1 || out_misaligned !== 1'b1 || out_region_err !== 1'b0 || err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL misaligned got idx=%0d mis=%b rgn=%b err=%0d want idx=1 mis=1 rgn=0 err=1",
               out_index, out_misaligned, out_region_err, err_count);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_target = 32'h1000_0000;
    in_pc4    = 32'h0000_0004;
    step();
    in_valid = 1'b0;
`ifdef JUMP_REGION_CHECK_EN
    exp_err = 2;
    n_tests++;
    if (out_region_err !== 1'b1) begin n_fail++; $display("FAIL region_flag got %b want 1", out_region_err); end
`else
    exp_err = 1;
    n_tests++;
    if (out_region_err !== 1'b0) begin n_fail++; $display("FAIL region_flag got %b want 0", out_region_err); end
`endif
    n_tests++;
    if (out_index !== 26'd0 || out_misaligned !== 1'b0 || err_count !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL region_entry got idx=%0d mis=%b err=%0d want idx=0 mis=0 err=%0d",
               out_index, out_misaligned, err_count, exp_err);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_push_pop();
    logic [SIZE-1:0] got[$];
    logic [31:0]     tgts[3] = '{32'h4, 32'h8, 32'hC};
    int              sent = 0;
    bit              saw_both_at_one = 0;
    bit              accept;
    in_pc4 = 32'h0000_0100;
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      out_ready = c[0];
      in_valid  = (sent < 3);
      in_target = (sent < 3) ? tgts[sent] : 32'h0;
      n_tests++;
      if (in_ready !== (mq.size() < 2) || out_valid !== (mq.size() > 0)) begin
        n_fail++; $display("FAIL pp_hs_%0d got ready=%b valid=%b want ready=%b valid=%b",
                           c, in_ready, out_valid, mq.size() < 2, mq.size() > 0);
      end
      if (mq.size() == 1 && in_valid && out_ready) saw_both_at_one = 1;
      if (out_valid && out_ready) got.push_back(out_index);
      accept = in_valid && in_ready;
      step();
      if (accept) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (!saw_both_at_one || got.size() != 3) begin
      n_fail++; $display("FAIL pp_count got %0d outputs (overlap=%0d) want 3 (overlap=1)", got.size(), saw_both_at_one);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (got[i] !== SIZE'(i + 1)) begin
          n_fail++; $display("FAIL pp_order_%0d got %0d want %0d", i, got[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int accepted = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_target = 32'h0000_0001;
    in_pc4    = 32'h0000_0004;
    for (int c = 0; c < 400 && accepted < 300; c++) begin
      if (in_ready) accepted++;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    out_ready = 1'b0;
    n_tests++;
    if (accepted != 300) begin n_fail++; $display("FAIL sat_accepts got %0d want 300", accepted); end
    n_tests++;
    if (err_count !== 8'd255 || m_err != 255) begin
      n_fail++; $display("FAIL sat_err_count got %0d want 255 (model %0d)", err_count, m_err);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc4    = 32'h0000_0100;
    in_target = 32'h0000_0021;
    step();
    in_target = 32'h0000_0024;
    step();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_full got valid=%b ready=%b want valid=1 ready=0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    mq.delete();
    m_err = 0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_count !== 8'd0 || out_index !== '0) begin
      n_fail++; $display("FAIL mid_reset got valid=%b ready=%b err=%0d idx=%0d want 0 1 0 0",
                         out_valid, in_ready, err_count, out_index);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid  = 1'b1;
    in_target = 32'h0000_0014;
    step();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_index !== 26'd5 || err_count !== 8'd0) begin
      n_fail++; $display("FAIL mid_after got valid=%b idx=%0d err=%0d want 1 5 0", out_valid, out_index, err_count);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_target = $urandom();
      if ($urandom_range(0, 1) == 1) in_target[1:0] = 2'b00;
      in_pc4 = $urandom();
      if ($urandom_range(0, 1) == 1) in_pc4[31:28] = in_target[31:28];
      n_tests++;
      if (in_ready !== (mq.size() < 2) || out_valid !== (mq.size() > 0) || err_count !== 8'(m_err)) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL rand_state_%0d got ready=%b valid=%b err=%0d want ready=%b valid=%b err=%0d",
                               c, in_ready, out_valid, err_count, mq.size() < 2, mq.size() > 0, m_err);
      end
      if (mq.size() > 0) begin
        n_tests++;
        if (out_index !== mq[0].idx || out_misaligned !== mq[0].mis || out_region_err !== mq[0].rgn) begin
          n_fail++; bad++;
          if (bad < 10) $display("FAIL rand_head_%0d got idx=%h mis=%b rgn=%b want idx=%h mis=%b rgn=%b",
                                 c, out_index, out_misaligned, out_region_err, mq[0].idx, mq[0].mis, mq[0].rgn);
        end
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_error_flags();
    test_push_pop();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jump_index_encoder.md
# jump_index_encoder

Converts a byte-addressed jump target back into the 26-bit J-format instruction index, the inverse of the datapath's shift-left-2 jump-address path. It sits in front of instruction-memory preload and self-check logic, where it packs J/JAL target fields. It also flags targets the J format cannot express. Requests enter through a valid/ready handshake, and results leave through a 2-entry output FIFO.

## Interface
- `SIZE`, 26, instruction index width; output byte offset width is SIZE+2
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  request present
- `in_ready`  out  1  block accepts request this cycle
- `in_target`  in  32  byte-addressed jump target
- `in_pc4`  in  32  PC+4 of the jump instruction
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  consumer takes head this cycle
- `out_index`  out  SIZE  encoded index, equal to in_target[SIZE+1:2]
- `out_misaligned`  out  1  in_target[1:0] != 0
- `out_region_err`  out  1  in_target[31:SIZE+2] != in_pc4[31:SIZE+2]
- `err_count`  out  8  saturating count of accepted requests with any error flag set

## Operation
- Accept occurs when `in_valid && in_ready`.
- On accept, the block encodes the request combinationally and pushes the entry {index, misaligned, region_err} into the FIFO tail at the same clock edge.
- Index = in_target[SIZE+1:2]. Low 2 bits are dropped even when misaligned; the flag is reported and the index is still produced.
- FIFO depth is 2; count ranges 0..2.
- `in_ready = (count != 2)`. A full FIFO blocks input regardless of `out_ready`; there is no same-cycle pass-through when full.
- `out_valid = (count != 0)`. Head fields are stable while `out_valid && !out_ready`.
- Pop occurs when `out_valid && out_ready`.
- Simultaneous push and pop at count 1: count stays 1, the head becomes the new entry, and no data is lost or duplicated.
- Simultaneous push and pop at count 0: impossible, since `out_valid` is 0.
- Pointers are 1 bit each and wrap modulo 2.
- `err_count` increments by 1 on each accept whose entry has misaligned or region_err set, and saturates at 255.
- Inputs are ignored when `in_ready` is 0.

## Timing
- Latency: an entry accepted at edge N appears at `out_*` with `out_valid` high after edge N, i.e. one cycle.
- Throughput: one request per cycle with `out_ready` held high.
- Reset (async assert, sync use after deassert) sets:
  - count 0 and both pointers 0
  - `out_valid` 0 and `in_ready` 1
  - `out_index` 0, `out_misaligned` 0, `out_region_err` 0
  - `err_count` 0
- Reset mid-operation discards all FIFO contents immediately. No partial entry survives, and the first accept after release is the new head.
- Storage cells are reset to 0, so head fields read 0 while empty.

## Configuration
- Macro `JUMP_REGION_CHECK_EN`.
- Defined: `out_region_err` is computed as above and contributes to `err_count`.
- Undefined: `out_region_err` is tied 0, `in_pc4` is unused, and the region comparator is not synthesized. `err_count` counts misaligned requests only.

## Test plan
- **Reset then single request:** target 0x0000_0004, pc4 0x0000_0100 -> one cycle later out_index 0x0000001, both flags 0, err_count 0.
- **Full backpressure:** out_ready=0, three back-to-back requests with targets 0x8, 0xC, 0x10 -> in_ready drops after the second accept. Release out_ready -> indices 2, 3, then 4 in order, with no loss.
- **Error flags:**
  - Target 0x0000_0006 -> out_index 1, misaligned 1, err_count 1.
  - Target 0x1000_0000 with pc4 0x0000_0004 -> region_err 1 with macro defined (err_count 2), or 0 without it (err_count stays 1).
- **Simultaneous push/pop at count 1:** stream targets 0x4, 0x8, 0xC with out_ready toggling 1/0 -> outputs 1, 2, 3 exactly once each, in order.
- **Saturation:** 300 accepted misaligned requests (target 0x1) -> err_count holds 255.
- **Reset mid-stream:** assert rst_n=0 with 2 entries queued -> out_valid 0, in_ready 1, err_count 0 immediately. After release, target 0x14 -> out_index 5 as head.
